// File: rtl/dif_pair_buf.sv
// Decimation-in-frequency pairing buffer: stores the first half of each frame
// and emits (n, n+HALF) sample pairs as the second half arrives.
module dif_pair_buf #(
    parameter int DATA_W       = 10,
    parameter int STAGE        = 0,
    parameter int TOTAL_STAGES = 8
) (
    input  logic                     mclk,
    input  logic                     i_rst_n,
    input  logic                     i_init,
    input  logic                     i_vld,
    input  logic signed [DATA_W-1:0] i_I,
    input  logic signed [DATA_W-1:0] i_Q,
    output logic                     o_vld,
    output logic signed [DATA_W-1:0] o_LI,
    output logic signed [DATA_W-1:0] o_LQ,
    output logic signed [DATA_W-1:0] o_RI,
    output logic signed [DATA_W-1:0] o_RQ,
    output logic [(((TOTAL_STAGES-STAGE) > 1) ? (TOTAL_STAGES-STAGE-1) : 1)-1:0] o_pair_idx
);

    localparam int CNT_W = TOTAL_STAGES - STAGE;
    localparam int LEN   = 2 ** CNT_W;
    localparam int HALF  = LEN / 2;
    localparam int IDX_W = (CNT_W > 1) ? (CNT_W - 1) : 1;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     accept;
    logic                     pair_phase;
    logic                     wr_en;
    logic                     pair_en;
    logic [IDX_W-1:0]         addr;
    logic signed [DATA_W-1:0] rd_I, rd_Q;

    logic                     vld_q, vld_d;
    logic signed [DATA_W-1:0] li_q, li_d;
    logic signed [DATA_W-1:0] lq_q, lq_d;
    logic signed [DATA_W-1:0] ri_q, ri_d;
    logic signed [DATA_W-1:0] rq_q, rq_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    // A flush cycle swallows the incoming sample, so it is never accepted.
    assign accept     = i_vld & ~i_init;
    assign pair_phase = cnt_q[CNT_W-1];
    assign wr_en      = accept & ~pair_phase;
    assign pair_en    = accept & pair_phase;

    always_comb begin
        cnt_d = cnt_q;
        if (i_init) begin
            cnt_d = '0;
        end else if (i_vld) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Store address is the sample offset within the current half; the same
    // offset addresses the write in FILL and the read in PAIR.
    generate
        if (HALF == 1) begin : g_single
            logic signed [DATA_W-1:0] st_I_q;
            logic signed [DATA_W-1:0] st_Q_q;

            assign addr = '0;

            always_ff @(posedge mclk) begin
                if (wr_en) begin
                    st_I_q <= i_I;
                    st_Q_q <= i_Q;
                end
            end

            assign rd_I = st_I_q;
            assign rd_Q = st_Q_q;
        end else begin : g_ram
            logic signed [DATA_W-1:0] mem_I [HALF];
            logic signed [DATA_W-1:0] mem_Q [HALF];

            assign addr = cnt_q[IDX_W-1:0];

            always_ff @(posedge mclk) begin
                if (wr_en) begin
                    mem_I[addr] <= i_I;
                    mem_Q[addr] <= i_Q;
                end
            end

            assign rd_I = mem_I[addr];
            assign rd_Q = mem_Q[addr];
        end
    endgenerate

    always_comb begin
        vld_d = pair_en;
        li_d  = li_q;
        lq_d  = lq_q;
        ri_d  = ri_q;
        rq_d  = rq_q;
        idx_d = idx_q;
        if (pair_en) begin
            li_d  = rd_I;
            lq_d  = rd_Q;
            ri_d  = i_I;
            rq_d  = i_Q;
            idx_d = addr;
        end
    end

    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= 1'b0;
            li_q  <= '0;
            lq_q  <= '0;
            ri_q  <= '0;
            rq_q  <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            li_q  <= li_d;
            lq_q  <= lq_d;
            ri_q  <= ri_d;
            rq_q  <= rq_d;
            idx_q <= idx_d;
        end
    end

    assign o_vld      = vld_q;
    assign o_LI       = li_q;
    assign o_LQ       = lq_q;
    assign o_RI       = ri_q;
    assign o_RQ       = rq_q;
    assign o_pair_idx = idx_q;

endmodule

// File: tb/tb_dif_pair_buf.sv
// Bench for dif_pair_buf: an 8-point and a 2-point instance driven from the
// same stream and compared every cycle against a frame-list model.
module tb_dif_pair_buf;

    localparam int DW = 10;

    logic                 mclk;
    logic                 i_rst_n;
    logic                 i_init;
    logic                 i_vld;
    logic signed [DW-1:0] i_I, i_Q;

    logic                 o_vld8, o_vld2;
    logic signed [DW-1:0] o_LI8, o_LQ8, o_RI8, o_RQ8;
    logic signed [DW-1:0] o_LI2, o_LQ2, o_RI2, o_RQ2;
    logic [1:0]           o_idx8;
    logic [0:0]           o_idx2;

    dif_pair_buf #(.DATA_W(DW), .STAGE(0), .TOTAL_STAGES(3)) u_dut8 (
        .mclk(mclk), .i_rst_n(i_rst_n), .i_init(i_init), .i_vld(i_vld),
        .i_I(i_I), .i_Q(i_Q), .o_vld(o_vld8),
        .o_LI(o_LI8), .o_LQ(o_LQ8), .o_RI(o_RI8), .o_RQ(o_RQ8),
        .o_pair_idx(o_idx8)
    );

    dif_pair_buf #(.DATA_W(DW), .STAGE(2), .TOTAL_STAGES(3)) u_dut2 (
        .mclk(mclk), .i_rst_n(i_rst_n), .i_init(i_init), .i_vld(i_vld),
        .i_I(i_I), .i_Q(i_Q), .o_vld(o_vld2),
        .o_LI(o_LI2), .o_LQ(o_LQ2), .o_RI(o_RI2), .o_RQ(o_RQ2),
        .o_pair_idx(o_idx2)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int total = 0;
    int bad   = 0;

    // Model: per instance, the list of samples accepted so far in the frame.
    int fI [2][8];
    int fQ [2][8];
    int fn [2];
    int ev [2];
    int eLI[2], eLQ[2], eRI[2], eRQ[2], eIdx[2];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            fn[k] = 0; ev[k] = 0;
            eLI[k] = 0; eLQ[k] = 0; eRI[k] = 0; eRQ[k] = 0; eIdx[k] = 0;
        end
    endtask

    task automatic model_update(input logic v, input int di, input int dq, input logic ini);
        for (int k = 0; k < 2; k++) begin
            int half;
            half = (k == 0) ? 4 : 1;
            ev[k] = 0;
            if (ini) begin
                fn[k] = 0;
            end else if (v) begin
                if (fn[k] >= half) begin
                    ev[k]   = 1;
                    eLI[k]  = fI[k][fn[k]-half];
                    eLQ[k]  = fQ[k][fn[k]-half];
                    eRI[k]  = di;
                    eRQ[k]  = dq;
                    eIdx[k] = fn[k] - half;
                end
                fI[k][fn[k]] = di;
                fQ[k][fn[k]] = dq;
                fn[k]++;
                if (fn[k] == 2 * half) fn[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("vld8", int'(o_vld8), ev[0]);
        chk("LI8",  int'(o_LI8),  eLI[0]);
        chk("LQ8",  int'(o_LQ8),  eLQ[0]);
        chk("RI8",  int'(o_RI8),  eRI[0]);
        chk("RQ8",  int'(o_RQ8),  eRQ[0]);
        chk("idx8", int'(o_idx8), eIdx[0]);
        chk("vld2", int'(o_vld2), ev[1]);
        chk("LI2",  int'(o_LI2),  eLI[1]);
        chk("LQ2",  int'(o_LQ2),  eLQ[1]);
        chk("RI2",  int'(o_RI2),  eRI[1]);
        chk("RQ2",  int'(o_RQ2),  eRQ[1]);
        chk("idx2", int'(o_idx2), eIdx[1]);
    endtask

    task automatic step(input logic v, input int di, input int dq, input logic ini);
        i_vld  = v;
        i_I    = DW'(di);
        i_Q    = DW'(dq);
        i_init = ini;
        @(posedge mclk);
        #1;
        model_update(v, di, dq, ini);
        check_all();
    endtask

    task automatic rnd_data(output int d);
        d = int'($urandom_range(0, 1023)) - 512;
    endtask

    initial begin
        int a, b;
        i_rst_n = 1'b1;
        i_init  = 1'b0;
        i_vld   = 1'b0;
        i_I     = '0;
        i_Q     = '0;
        model_reset();
        #2 i_rst_n = 1'b0;
        @(posedge mclk);
        #1;
        check_all();
        #3 i_rst_n = 1'b1;

        // Single frame, continuous valid.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i, -i, 1'b0);
            if (i == 3) chk("s1_no_strobe_yet", int'(o_vld8), 0);
            if (i == 4) begin
                chk("s1_first_LI", int'(o_LI8), 0);
                chk("s1_first_RI", int'(o_RI8), 4);
                chk("s1_first_RQ", int'(o_RQ8), -4);
            end
            if (i == 7) chk("s1_last_idx", int'(o_idx8), 3);
        end
        step(1'b0, 99, 99, 1'b0);
        chk("s1_hold_RI", int'(o_RI8), 7);

        // Same stream with valid toggling; garbage data in the gaps.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i, -i, 1'b0);
            rnd_data(a); rnd_data(b);
            step(1'b0, a, b, 1'b0);
        end

        // Two back-to-back frames.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i, -i, 1'b0);
            if (i == 12) begin
                chk("s3_f2_LI", int'(o_LI8), 8);
                chk("s3_f2_RI", int'(o_RI8), 12);
            end
        end

        // Flush mid-frame, then a fresh frame.
        for (int i = 0; i < 3; i++) step(1'b1, i, -i, 1'b0);
        step(1'b1, 55, 55, 1'b1);
        for (int i = 10; i < 18; i++) begin
            step(1'b1, i, -i, 1'b0);
            if (i < 14) chk("s4_no_strobe", int'(o_vld8), 0);
            if (i == 14) chk("s4_first_LI", int'(o_LI8), 10);
        end

        // Asynchronous reset while a pair is being presented.
        for (int i = 0; i < 5; i++) step(1'b1, i + 20, i, 1'b0);
        chk("s5_vld_before_rst", int'(o_vld8), 1);
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge mclk);
        #1;
        check_all();
        #2 i_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, i, -i, 1'b0);

        // Two-point stage pairing after a flush.
        step(1'b0, 0, 0, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, i, -i, 1'b0);
            if (i == 4) begin
                chk("s6_LI2", int'(o_LI2), 3);
                chk("s6_RI2", int'(o_RI2), 4);
            end
        end

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 600; n++) begin
            logic v, ini;
            v   = ($urandom_range(0, 3) != 0);
            ini = ($urandom_range(0, 49) == 0);
            rnd_data(a); rnd_data(b);
            step(v, a, b, ini);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dif_pair_buf.md
DIF_PAIR_BUF -- requirements
Module: dif_pair_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 10: width of each signed I/Q sample.
REQ-002 SHALL have parameter STAGE, default 0: index of this FFT stage.
REQ-003 SHALL have parameter TOTAL_STAGES, default 8: log2 of the full FFT length.
REQ-004 SHALL derive localparams LEN = 2**(TOTAL_STAGES-STAGE) and HALF = LEN/2; TOTAL_STAGES-STAGE >= 1 is required.
REQ-005 SHALL have port mclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_init, input, 1 bit: synchronous flush.
REQ-008 SHALL have port i_vld, input, 1 bit: a serial input sample is present.
REQ-009 SHALL have ports i_I and i_Q, input, signed DATA_W each: the serial complex sample.
REQ-010 SHALL have port o_vld, output, 1 bit: a butterfly pair is present.
REQ-011 SHALL have ports o_LI, o_LQ, o_RI and o_RQ, output, signed DATA_W each: the pair, sample n and sample n+HALF.
REQ-012 SHALL have port o_pair_idx, output, max(1,log2(HALF)) bits: index n of the pair within its frame.

Function
REQ-013 SHALL keep a sample counter cnt, width log2(LEN), that advances by 1 only on each accepted i_vld and wraps LEN-1 -> 0.
REQ-014 SHALL, on i_vld with cnt < HALF (FILL phase), write {i_I,i_Q} into a HALF-deep delay store at address cnt and hold o_vld at 0 on the next cycle.
REQ-015 SHALL, on i_vld with cnt >= HALF (PAIR phase), register on the next edge: o_LI/o_LQ = stored sample (cnt-HALF), o_RI/o_RQ = i_I/i_Q, o_pair_idx = cnt-HALF, o_vld = 1.
REQ-016 SHALL have a latency of exactly 1 cycle from the accepted second-half input to o_vld.
REQ-017 SHALL make o_vld a 1-cycle strobe per pair; HALF strobes are emitted per LEN-sample frame.
REQ-018 SHALL hold o_LI/o_LQ/o_RI/o_RQ/o_pair_idx at their last values while o_vld = 0.
REQ-019 SHALL tolerate arbitrary gaps in i_vld: the counter and store are frozen while i_vld = 0, and pairing follows accepted-sample order only.
REQ-020 SHALL accept back-to-back frames with no bubble; sample 0 of frame k+1 may follow sample LEN-1 of frame k on the very next cycle.
REQ-021 SHALL, for LEN = 2 (HALF = 1), use a single register as the store, keep o_pair_idx at 0, and pair every even/odd sample.
REQ-022 SHALL, while i_init = 1 on an edge, set cnt to 0 and o_vld to 0 and ignore i_vld that cycle; store contents and data outputs are left unchanged.
REQ-023 SHALL, when i_init is asserted mid-frame, discard the partial frame; the first accepted sample after i_init is frame sample 0.
REQ-024 SHALL NOT create any combinational path from any input to any output; all outputs are registered.
REQ-025 SHALL be able to implement the store as an inferred RAM with a registered read or as a shift register, provided REQ-016 holds.

Reset
REQ-026 SHALL, while i_rst_n = 0, asynchronously force cnt = 0, o_vld = 0, o_LI = o_LQ = o_RI = o_RQ = 0 and o_pair_idx = 0.
REQ-027 SHALL NOT reset the delay-store contents.
REQ-028 SHALL, after i_rst_n is released, treat the first accepted sample as frame sample 0.

Verification
REQ-029 SHALL pass this scenario: TOTAL_STAGES=3, STAGE=0 (LEN 8), continuous i_vld, I = 0..7, Q = -I -> o_vld on the cycles after inputs 4,5,6,7 with (LI,RI) = (0,4),(1,5),(2,6),(3,7), LQ = -LI, RQ = -RI, and o_pair_idx = 0,1,2,3.
REQ-030 SHALL pass this scenario: the same stream with i_vld toggling 1,0,1,0 -> identical pair values and order, each o_vld exactly 1 cycle after its driving input.
REQ-031 SHALL pass this scenario: two back-to-back frames, I = 0..15 -> 8 strobes; the second frame pairs are (8,12),(9,13),(10,14),(11,15).
REQ-032 SHALL pass this scenario: i_init pulsed after inputs 0,1,2, then I = 10..17 -> pairs (10,14),(11,15),(12,16),(13,17) and no strobe before input 14.
REQ-033 SHALL pass this scenario: i_rst_n asserted asynchronously between clock edges while o_vld = 1 -> o_vld and all data outputs read 0 immediately; after release, frame restarts as in REQ-029.
REQ-034 SHALL pass this scenario: TOTAL_STAGES=3, STAGE=2 (LEN 2), I = 1..6 -> pairs (1,2),(3,4),(5,6) with o_pair_idx constant 0.
